afu_tx_shim: RTL and testbench

AFU-side TX request shim feeding the SPL top-level TX ports (`afu_tx_rd_*`, `afu_tx_wr_*`, `afu_tx_intr_valid`). It decouples user AFU logic from SPL back-pressure with one read-request FIFO and one write/interrupt FIFO, each with a valid/ready push interface. It issues at most one read and one write per cycle into SPL, honouring `spl_tx_*_almostfull`. It caps outstanding reads with a counter that is credited back by `spl_rx_rd_valid`.

---
 rtl/spl_shim_pkg.sv | 18 +
 rtl/spl_shim_fifo.sv | 57 +++++
 rtl/afu_tx_shim.sv | 157 +++++++++++++++
 tb/tb_afu_tx_shim.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spl_shim_pkg.sv
// Shared widths and FIFO entry layouts for the AFU-side SPL TX request shim.
package spl_shim_pkg;

    localparam int SPL_HDR_W  = 99;
    localparam int SPL_DATA_W = 512;

    typedef logic [SPL_HDR_W-1:0] rd_entry_t;

    typedef struct packed {
        logic                  intr;
        logic [SPL_HDR_W-1:0]  hdr;
        logic [SPL_DATA_W-1:0] data;
    } wr_entry_t;

    localparam int RD_ENTRY_W = $bits(rd_entry_t);
    localparam int WR_ENTRY_W = $bits(wr_entry_t);

endpackage

// File: rtl/spl_shim_fifo.sv
// Synchronous FIFO with occupancy count and a synchronous flush.
// The extra pointer MSB tells a full FIFO apart from an empty one.
module spl_shim_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/afu_tx_shim.sv
// AFU-side TX request shim: buffers user read and write/interrupt requests and
// issues them into SPL under almost-full back-pressure and a read credit limit.
module afu_tx_shim
    import spl_shim_pkg::*;
#(
    parameter int FIFO_AW            = 3,
    parameter int MAX_RD_OUTSTANDING = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  spl_enable,
    input  logic                  spl_reset,
    input  logic                  usr_rd_valid,
    input  logic [SPL_HDR_W-1:0]  usr_rd_hdr,
    output logic                  usr_rd_ready,
    input  logic                  usr_wr_valid,
    input  logic                  usr_wr_intr,
    input  logic [SPL_HDR_W-1:0]  usr_wr_hdr,
    input  logic [SPL_DATA_W-1:0] usr_wr_data,
    output logic                  usr_wr_ready,
    input  logic                  spl_tx_rd_almostfull,
    input  logic                  spl_tx_wr_almostfull,
    input  logic                  spl_rx_rd_valid,
    output logic                  afu_tx_rd_valid,
    output logic [SPL_HDR_W-1:0]  afu_tx_rd_hdr,
    output logic                  afu_tx_wr_valid,
    output logic                  afu_tx_intr_valid,
    output logic [SPL_HDR_W-1:0]  afu_tx_wr_hdr,
    output logic [SPL_DATA_W-1:0] afu_tx_data,
    output logic [7:0]            rd_outstanding,
    output logic                  shim_idle
);

    localparam logic [8:0] RD_CAP = 9'(MAX_RD_OUTSTANDING);

    rd_entry_t        rd_dout;
    wr_entry_t        wr_din;
    wr_entry_t        wr_dout;
    logic [FIFO_AW:0] rd_count;
    logic [FIFO_AW:0] wr_count;
    logic             rd_full;
    logic             rd_empty;
    logic             wr_full;
    logic             wr_empty;
    logic             rd_push;
    logic             wr_push;
    logic             rd_issue;
    logic             wr_issue;
    logic             rd_valid_q;
    logic             wr_valid_q;
    logic             intr_valid_q;
    logic [8:0]       rd_committed;
    logic [7:0]       rd_out_nxt;
    logic             underflow_evt;
    logic             err_underflow;

    assign usr_rd_ready = ~rd_full & ~spl_reset;
    assign usr_wr_ready = ~wr_full & ~spl_reset;
    assign rd_push      = usr_rd_valid & usr_rd_ready;
    assign wr_push      = usr_wr_valid & usr_wr_ready;
    assign wr_din       = {usr_wr_intr, usr_wr_hdr, usr_wr_data};

    spl_shim_fifo #(.WIDTH(RD_ENTRY_W), .AW(FIFO_AW)) u_rd_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (spl_reset),
        .push    (rd_push),
        .din     (usr_rd_hdr),
        .pop     (rd_issue),
        .dout    (rd_dout),
        .count   (rd_count),
        .full    (rd_full),
        .empty   (rd_empty)
    );

    spl_shim_fifo #(.WIDTH(WR_ENTRY_W), .AW(FIFO_AW)) u_wr_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (spl_reset),
        .push    (wr_push),
        .din     (wr_din),
        .pop     (wr_issue),
        .dout    (wr_dout),
        .count   (wr_count),
        .full    (wr_full),
        .empty   (wr_empty)
    );

    // The read sitting in the output register is not yet in rd_outstanding,
    // so count it here or the cap would be overshot by one.
    assign rd_committed = {1'b0, rd_outstanding} + {8'd0, rd_valid_q};

    assign rd_issue = ~rd_empty & ~spl_tx_rd_almostfull & spl_enable & ~spl_reset
                    & (rd_committed < RD_CAP);
    assign wr_issue = ~wr_empty & ~spl_tx_wr_almostfull & spl_enable & ~spl_reset;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q    <= 1'b0;
            afu_tx_rd_hdr <= '0;
        end else begin
            rd_valid_q <= rd_issue;
            if (rd_issue) begin
                afu_tx_rd_hdr <= rd_dout;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_valid_q    <= 1'b0;
            intr_valid_q  <= 1'b0;
            afu_tx_wr_hdr <= '0;
            afu_tx_data   <= '0;
        end else begin
            wr_valid_q   <= wr_issue & ~wr_dout.intr;
            intr_valid_q <= wr_issue & wr_dout.intr;
            if (wr_issue) begin
                afu_tx_wr_hdr <= wr_dout.hdr;
                afu_tx_data   <= wr_dout.data;
            end
        end
    end

    assign afu_tx_rd_valid   = rd_valid_q & ~spl_reset;
    assign afu_tx_wr_valid   = wr_valid_q & ~spl_reset;
    assign afu_tx_intr_valid = intr_valid_q & ~spl_reset;

    always_comb begin
        rd_out_nxt    = rd_outstanding;
        underflow_evt = 1'b0;
        if (afu_tx_rd_valid && !spl_rx_rd_valid) begin
            rd_out_nxt = rd_outstanding + 8'd1;
        end else if (!afu_tx_rd_valid && spl_rx_rd_valid) begin
            if (rd_outstanding == 8'd0) begin
                underflow_evt = 1'b1;
            end else begin
                rd_out_nxt = rd_outstanding - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_outstanding <= '0;
            err_underflow  <= 1'b0;
        end else begin
            rd_outstanding <= spl_reset ? 8'd0 : rd_out_nxt;
            if (underflow_evt && !spl_reset) begin
                err_underflow <= 1'b1;
            end
        end
    end

    assign shim_idle = (rd_count == '0) && (wr_count == '0) && (rd_outstanding == 8'd0);

endmodule

// File: tb/tb_afu_tx_shim.sv
// Self-checking bench for afu_tx_shim: scoreboarded issue order plus
// table-driven write pushes and hand-written credit/flush sequences.
module tb_afu_tx_shim;
    import spl_shim_pkg::*;

    typedef struct {
        logic                  intr;
        logic [SPL_HDR_W-1:0]  hdr;
        logic [SPL_DATA_W-1:0] data;
        bit                    exp_acc;
    } wr_vec_t;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  spl_enable;
    logic                  spl_reset;
    logic                  usr_rd_valid;
    logic [SPL_HDR_W-1:0]  usr_rd_hdr;
    logic                  usr_rd_ready;
    logic                  usr_wr_valid;
    logic                  usr_wr_intr;
    logic [SPL_HDR_W-1:0]  usr_wr_hdr;
    logic [SPL_DATA_W-1:0] usr_wr_data;
    logic                  usr_wr_ready;
    logic                  spl_tx_rd_almostfull;
    logic                  spl_tx_wr_almostfull;
    logic                  spl_rx_rd_valid;
    logic                  afu_tx_rd_valid;
    logic [SPL_HDR_W-1:0]  afu_tx_rd_hdr;
    logic                  afu_tx_wr_valid;
    logic                  afu_tx_intr_valid;
    logic [SPL_HDR_W-1:0]  afu_tx_wr_hdr;
    logic [SPL_DATA_W-1:0] afu_tx_data;
    logic [7:0]            rd_outstanding;
    logic                  shim_idle;

    logic                  usr_rd_ready4;
    logic                  usr_wr_ready4;
    logic                  afu_tx_rd_valid4;
    logic [SPL_HDR_W-1:0]  afu_tx_rd_hdr4;
    logic                  afu_tx_wr_valid4;
    logic                  afu_tx_intr_valid4;
    logic [SPL_HDR_W-1:0]  afu_tx_wr_hdr4;
    logic [SPL_DATA_W-1:0] afu_tx_data4;
    logic [7:0]            rd_outstanding4;
    logic                  shim_idle4;

    always #5 clk = ~clk;

    afu_tx_shim #(.FIFO_AW(3), .MAX_RD_OUTSTANDING(64)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .spl_enable           (spl_enable),
        .spl_reset            (spl_reset),
        .usr_rd_valid         (usr_rd_valid),
        .usr_rd_hdr           (usr_rd_hdr),
        .usr_rd_ready         (usr_rd_ready),
        .usr_wr_valid         (usr_wr_valid),
        .usr_wr_intr          (usr_wr_intr),
        .usr_wr_hdr           (usr_wr_hdr),
        .usr_wr_data          (usr_wr_data),
        .usr_wr_ready         (usr_wr_ready),
        .spl_tx_rd_almostfull (spl_tx_rd_almostfull),
        .spl_tx_wr_almostfull (spl_tx_wr_almostfull),
        .spl_rx_rd_valid      (spl_rx_rd_valid),
        .afu_tx_rd_valid      (afu_tx_rd_valid),
        .afu_tx_rd_hdr        (afu_tx_rd_hdr),
        .afu_tx_wr_valid      (afu_tx_wr_valid),
        .afu_tx_intr_valid    (afu_tx_intr_valid),
        .afu_tx_wr_hdr        (afu_tx_wr_hdr),
        .afu_tx_data          (afu_tx_data),
        .rd_outstanding       (rd_outstanding),
        .shim_idle            (shim_idle)
    );

    // Second instance with a small read cap, only observed in the credit test.
    afu_tx_shim #(.FIFO_AW(3), .MAX_RD_OUTSTANDING(4)) dut4 (
        .clk                  (clk),
        .reset_n              (reset_n),
        .spl_enable           (spl_enable),
        .spl_reset            (spl_reset),
        .usr_rd_valid         (usr_rd_valid),
        .usr_rd_hdr           (usr_rd_hdr),
        .usr_rd_ready         (usr_rd_ready4),
        .usr_wr_valid         (usr_wr_valid),
        .usr_wr_intr          (usr_wr_intr),
        .usr_wr_hdr           (usr_wr_hdr),
        .usr_wr_data          (usr_wr_data),
        .usr_wr_ready         (usr_wr_ready4),
        .spl_tx_rd_almostfull (spl_tx_rd_almostfull),
        .spl_tx_wr_almostfull (spl_tx_wr_almostfull),
        .spl_rx_rd_valid      (spl_rx_rd_valid),
        .afu_tx_rd_valid      (afu_tx_rd_valid4),
        .afu_tx_rd_hdr        (afu_tx_rd_hdr4),
        .afu_tx_wr_valid      (afu_tx_wr_valid4),
        .afu_tx_intr_valid    (afu_tx_intr_valid4),
        .afu_tx_wr_hdr        (afu_tx_wr_hdr4),
        .afu_tx_data          (afu_tx_data4),
        .rd_outstanding       (rd_outstanding4),
        .shim_idle            (shim_idle4)
    );

    int        cyc    = 0;
    int        n_chk  = 0;
    int        n_fail = 0;
    int        n_rd4  = 0;
    rd_entry_t rd_exp_q[$];
    wr_entry_t wr_exp_q[$];
    int        rd_cyc_q[$];
    int        wr_cyc_q[$];
    bit        wr_kind_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (afu_tx_rd_valid) begin
            rd_cyc_q.push_back(cyc);
            check("rd_exp_avail", 640'(rd_exp_q.size() != 0), 640'd1);
            if (rd_exp_q.size() != 0) check("rd_hdr", 640'(afu_tx_rd_hdr), 640'(rd_exp_q.pop_front()));
        end
        if (afu_tx_wr_valid || afu_tx_intr_valid) begin
            check("wr_intr_exclusive", 640'(afu_tx_wr_valid & afu_tx_intr_valid), 640'd0);
            wr_cyc_q.push_back(cyc);
            wr_kind_q.push_back(afu_tx_intr_valid);
            check("wr_exp_avail", 640'(wr_exp_q.size() != 0), 640'd1);
            if (wr_exp_q.size() != 0)
                check("wr_entry", 640'({afu_tx_intr_valid, afu_tx_wr_hdr, afu_tx_data}),
                      640'(wr_exp_q.pop_front()));
        end
        if (afu_tx_rd_valid4) n_rd4++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_rd(input rd_entry_t h, output bit acc, output int c);
        usr_rd_valid = 1'b1;
        usr_rd_hdr   = h;
        #1;
        acc = usr_rd_ready;
        if (acc) rd_exp_q.push_back(h);
        @(posedge clk);
        #1;
        c = cyc;
        usr_rd_valid = 1'b0;
    endtask

    task automatic push_wr(input wr_entry_t e, output bit acc, output int c);
        usr_wr_valid = 1'b1;
        usr_wr_intr  = e.intr;
        usr_wr_hdr   = e.hdr;
        usr_wr_data  = e.data;
        #1;
        acc = usr_wr_ready;
        if (acc) wr_exp_q.push_back(e);
        @(posedge clk);
        #1;
        c = cyc;
        usr_wr_valid = 1'b0;
    endtask

    task automatic complete(input int n);
        spl_rx_rd_valid = 1'b1;
        tick(n);
        spl_rx_rd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin
        wr_vec_t   vec [11];
        wr_entry_t e;
        bit        acc;
        int        c;
        int        t0;
        int        base;

        for (int i = 0; i < 9; i++) begin
            vec[i].intr    = 1'b0;
            vec[i].hdr     = 99'(32'hA000 + i);
            vec[i].data    = {16{32'(i) ^ 32'h5A5A_0000}};
            vec[i].exp_acc = (i < 8);
        end
        vec[9].intr  = 1'b0; vec[9].hdr  = 99'h5A5; vec[9].data  = 512'hDEAD_0001; vec[9].exp_acc  = 1'b1;
        vec[10].intr = 1'b1; vec[10].hdr = 99'h1E1; vec[10].data = 512'hBEEF_0002; vec[10].exp_acc = 1'b1;

        reset_n = 1'b0; spl_enable = 1'b1; spl_reset = 1'b0;
        usr_rd_valid = 1'b0; usr_rd_hdr = '0;
        usr_wr_valid = 1'b0; usr_wr_intr = 1'b0; usr_wr_hdr = '0; usr_wr_data = '0;
        spl_tx_rd_almostfull = 1'b0; spl_tx_wr_almostfull = 1'b0; spl_rx_rd_valid = 1'b0;
        tick(2);
        check("rst_rd_valid", 640'(afu_tx_rd_valid), 640'd0);
        check("rst_wr_valid", 640'(afu_tx_wr_valid), 640'd0);
        check("rst_intr_valid", 640'(afu_tx_intr_valid), 640'd0);
        check("rst_rd_hdr", 640'(afu_tx_rd_hdr), 640'd0);
        check("rst_wr_hdr", 640'(afu_tx_wr_hdr), 640'd0);
        check("rst_data", 640'(afu_tx_data), 640'd0);
        check("rst_outstanding", 640'(rd_outstanding), 640'd0);
        check("rst_idle", 640'(shim_idle), 640'd1);
        reset_n = 1'b1;
        tick(1);
        check("rst_rd_ready", 640'(usr_rd_ready), 640'd1);
        check("rst_wr_ready", 640'(usr_wr_ready), 640'd1);

        // Three reads, no back-pressure: consecutive issues two cycles after first push.
        t0 = 0;
        for (int i = 1; i <= 3; i++) begin
            push_rd(99'(i), acc, c);
            check("rd_push_acc", 640'(acc), 640'd1);
            if (i == 1) t0 = c;
        end
        tick(4);
        check("rd_issue_count", 640'(rd_cyc_q.size()), 640'd3);
        for (int i = 0; i < 3; i++) check("rd_issue_cycle", 640'(rd_cyc_q[i]), 640'(t0 + 1 + i));
        check("rd_outstanding_3", 640'(rd_outstanding), 640'd3);
        check("rd_idle_busy", 640'(shim_idle), 640'd0);
        complete(3);
        tick(1);
        check("rd_outstanding_drain", 640'(rd_outstanding), 640'd0);

        // Read cap of 4 on dut4: six pushed, four issued until credits return.
        base = n_rd4;
        for (int i = 0; i < 6; i++) push_rd(99'h100 + 99'(i), acc, c);
        tick(6);
        check("cap_issued", 640'(n_rd4 - base), 640'd4);
        check("cap_outstanding", 640'(rd_outstanding4), 640'd4);
        complete(2);
        tick(5);
        check("cap_issued_after_credit", 640'(n_rd4 - base), 640'd6);
        check("cap_final", 640'(rd_outstanding4), 640'd4);
        check("cap_dut64_outstanding", 640'(rd_outstanding), 640'd4);
        complete(4);
        tick(1);
        check("cap_drain4", 640'(rd_outstanding4), 640'd0);
        check("cap_drain64", 640'(rd_outstanding), 640'd0);

        // Nine writes against almost-full: eight fit, ninth refused, then drain in order.
        spl_tx_wr_almostfull = 1'b1;
        wr_cyc_q.delete(); wr_kind_q.delete();
        for (int i = 0; i < 9; i++) begin
            e = {vec[i].intr, vec[i].hdr, vec[i].data};
            push_wr(e, acc, c);
            check("wr_push_acc", 640'(acc), 640'(vec[i].exp_acc));
        end
        check("wr_ready_full", 640'(usr_wr_ready), 640'd0);
        check("wr_no_issue_af", 640'(wr_cyc_q.size()), 640'd0);
        spl_tx_wr_almostfull = 1'b0;
        tick(12);
        check("wr_issue_count", 640'(wr_cyc_q.size()), 640'd8);
        check("wr_issue_back2back", 640'(wr_cyc_q[7] - wr_cyc_q[0]), 640'd7);
        check("wr_ready_recovered", 640'(usr_wr_ready), 640'd1);

        // Write followed by interrupt.
        wr_cyc_q.delete(); wr_kind_q.delete();
        for (int i = 9; i < 11; i++) begin
            e = {vec[i].intr, vec[i].hdr, vec[i].data};
            push_wr(e, acc, c);
            check("wi_push_acc", 640'(acc), 640'(vec[i].exp_acc));
        end
        tick(4);
        check("wi_issue_count", 640'(wr_cyc_q.size()), 640'd2);
        check("wi_first_is_write", 640'(wr_kind_q[0]), 640'd0);
        check("wi_second_is_intr", 640'(wr_kind_q[1]), 640'd1);
        check("wi_consecutive", 640'(wr_cyc_q[1] - wr_cyc_q[0]), 640'd1);

        // Issue and completion together at count 5.
        for (int i = 0; i < 5; i++) push_rd(99'h200 + 99'(i), acc, c);
        tick(4);
        check("cnt_at_5", 640'(rd_outstanding), 640'd5);
        push_rd(99'h2FF, acc, c);
        tick(1);
        spl_rx_rd_valid = 1'b1;
        tick(1);
        spl_rx_rd_valid = 1'b0;
        check("same_cycle_issue", 640'(rd_cyc_q[rd_cyc_q.size() - 1]), 640'(c + 1));
        tick(1);
        check("cnt_same_cycle", 640'(rd_outstanding), 640'd5);
        check("no_underflow_yet", 640'(dut.err_underflow), 640'd0);
        complete(5);
        tick(1);
        check("cnt_zero", 640'(rd_outstanding), 640'd0);
        complete(1);
        tick(1);
        check("cnt_saturate", 640'(rd_outstanding), 640'd0);
        check("err_underflow_set", 640'(dut.err_underflow), 640'd1);

        // Flush with two outstanding and four queued.
        push_rd(99'h301, acc, c);
        push_rd(99'h302, acc, c);
        tick(4);
        check("flush_pre_cnt", 640'(rd_outstanding), 640'd2);
        spl_tx_rd_almostfull = 1'b1;
        for (int i = 0; i < 4; i++) push_rd(99'h310 + 99'(i), acc, c);
        spl_reset = 1'b1;
        #1;
        check("flush_rd_ready_low", 640'(usr_rd_ready), 640'd0);
        check("flush_wr_ready_low", 640'(usr_wr_ready), 640'd0);
        @(posedge clk);
        #1;
        spl_reset = 1'b0;
        spl_tx_rd_almostfull = 1'b0;
        rd_exp_q.delete();
        base = rd_cyc_q.size();
        tick(2);
        check("flush_idle", 640'(shim_idle), 640'd1);
        check("flush_cnt", 640'(rd_outstanding), 640'd0);
        check("flush_rd_ready", 640'(usr_rd_ready), 640'd1);
        tick(4);
        check("flush_no_issue", 640'(rd_cyc_q.size()), 640'(base));

        check("rd_queue_drained", 640'(rd_exp_q.size()), 640'd0);
        check("wr_queue_drained", 640'(wr_exp_q.size()), 640'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
